// File: rtl/response_sm.sv
`default_nettype none
// ============================================================================
// Module   : response_sm
// Purpose  : Serialises one response packet onto an AXI-stream tx interface.
//            A packet is a three-word header (RSN, RC, RDC) followed by RDC
//            data words passed through from the command processor. tlast
//            marks the final word of the frame. rsp_done pulses for one
//            cycle when the packet is complete.
// Ports    : clk, reset              - clock, synchronous active-high reset
//            send_rsp                - start a packet (sampled in IDLE only)
//            rsp_ser_num/rsp_code    - header words, latched at start
//            rsp_data_count          - number of data words, latched at start
//            rd_tdata/tvalid/tready  - data word source (pass-through)
//            tx_tdata/tvalid/tkeep/tlast/tready - AXI-stream to tx FIFO
//            rsp_busy, rsp_done      - status
// Revision : 1.0 - initial release
// ============================================================================
module response_sm #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              send_rsp,
  input  logic [DATA_W-1:0] rsp_ser_num,
  input  logic [DATA_W-1:0] rsp_code,
  input  logic [CNT_W-1:0]  rsp_data_count,
  input  logic [DATA_W-1:0] rd_tdata,
  input  logic              rd_tvalid,
  output logic              rd_tready,
  output logic [DATA_W-1:0] tx_tdata,
  output logic              tx_tvalid,
  output logic [0:3]        tx_tkeep,
  output logic              tx_tlast,
  input  logic              tx_tready,
  output logic              rsp_busy,
  output logic              rsp_done
);

  typedef enum logic [5:0] {
    IDLE     = 6'b000001,
    SEND_RSN = 6'b000010,
    SEND_RC  = 6'b000100,
    SEND_RDC = 6'b001000,
    SEND_RD  = 6'b010000,
    DONE     = 6'b100000
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   rsn_q, rsn_d;
  logic [DATA_W-1:0]   rc_q, rc_d;
  logic [CNT_W-1:0]    rdc_q, rdc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy_q;
  logic                done_q;

  logic                w_valid;
  logic [DATA_W-1:0]   w_data;
  logic                w_last;
  logic                w_rd_ready;
  logic                w_rdc_zero;
  logic                w_cnt_one;

  assign w_rdc_zero = (rdc_q == '0);
  assign w_cnt_one  = (cnt_q == CNT_W'(1));

  // --------------------------------------------------------------------------
  // Next-state logic. The counter is loaded when leaving SEND_RDC so it holds
  // RDC on entry to SEND_RD; the packet leaves SEND_RD on the transfer made
  // with the counter at 1, so it never reaches 0 and cannot wrap.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    rsn_d   = rsn_q;
    rc_d    = rc_q;
    rdc_d   = rdc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (send_rsp) begin
          rsn_d   = rsp_ser_num;
          rc_d    = rsp_code;
          rdc_d   = rsp_data_count;
          state_d = SEND_RSN;
        end
      end
      SEND_RSN: begin
        if (tx_tready) state_d = SEND_RC;
      end
      SEND_RC: begin
        if (tx_tready) state_d = SEND_RDC;
      end
      SEND_RDC: begin
        if (tx_tready) begin
          if (w_rdc_zero) begin
            state_d = DONE;
          end else begin
            cnt_d   = rdc_q;
            state_d = SEND_RD;
          end
        end
      end
      SEND_RD: begin
        if (rd_tvalid && tx_tready) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (w_cnt_one) state_d = DONE;
        end
      end
      DONE: begin
        // send_rsp is deliberately not looked at here.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rsn_q   <= '0;
      rc_q    <= '0;
      rdc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rsn_q   <= rsn_d;
      rc_q    <= rc_d;
      rdc_q   <= rdc_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
    end
  end

  // --------------------------------------------------------------------------
  // Stream outputs. Header words come from the latched registers; data words
  // are a combinational pass-through of the rd stream.
  // --------------------------------------------------------------------------
  always_comb begin
    w_valid    = 1'b0;
    w_data     = '0;
    w_last     = 1'b0;
    w_rd_ready = 1'b0;
    case (state_q)
      SEND_RSN: begin
        w_valid = 1'b1;
        w_data  = rsn_q;
      end
      SEND_RC: begin
        w_valid = 1'b1;
        w_data  = rc_q;
      end
      SEND_RDC: begin
        w_valid = 1'b1;
        w_data  = DATA_W'(rdc_q);
        w_last  = w_rdc_zero;
      end
      SEND_RD: begin
        w_valid    = rd_tvalid;
        w_data     = rd_tdata;
        w_last     = rd_tvalid && w_cnt_one;
        w_rd_ready = tx_tready;
      end
      default: begin
        w_valid = 1'b0;
      end
    endcase
  end

  // Outputs are forced quiet while reset is asserted so a partial frame is
  // cut off immediately, never with a tlast.
  assign tx_tvalid = w_valid && !reset;
  assign tx_tdata  = w_data;
  assign tx_tlast  = w_last && !reset;
  assign tx_tkeep  = {4{tx_tvalid}};
  assign rd_tready = w_rd_ready && !reset;
  assign rsp_busy  = busy_q && !reset;
  assign rsp_done  = done_q && !reset;

endmodule
`default_nettype wire

// File: tb/tb_response_sm.sv
`default_nettype none
// ============================================================================
// Module   : tb_response_sm
// Purpose  : Self-checking directed testbench for response_sm.
// Revision : 1.0 - initial release
// ============================================================================
module tb_response_sm;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              send_rsp;
  logic [DATA_W-1:0] rsp_ser_num;
  logic [DATA_W-1:0] rsp_code;
  logic [CNT_W-1:0]  rsp_data_count;
  logic [DATA_W-1:0] rd_tdata;
  logic              rd_tvalid;
  logic              rd_tready;
  logic [DATA_W-1:0] tx_tdata;
  logic              tx_tvalid;
  logic [0:3]        tx_tkeep;
  logic              tx_tlast;
  logic              tx_tready;
  logic              rsp_busy;
  logic              rsp_done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  response_sm #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .send_rsp       (send_rsp),
    .rsp_ser_num    (rsp_ser_num),
    .rsp_code       (rsp_code),
    .rsp_data_count (rsp_data_count),
    .rd_tdata       (rd_tdata),
    .rd_tvalid      (rd_tvalid),
    .rd_tready      (rd_tready),
    .tx_tdata       (tx_tdata),
    .tx_tvalid      (tx_tvalid),
    .tx_tkeep       (tx_tkeep),
    .tx_tlast       (tx_tlast),
    .tx_tready      (tx_tready),
    .rsp_busy       (rsp_busy),
    .rsp_done       (rsp_done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Data word i of a packet is base + i.
  function automatic logic [31:0] rd_word(input logic [31:0] base, input int idx);
    return base + 32'(idx);
  endfunction

  // All outputs must be idle.
  task automatic check_quiet(input string tag);
    check({tag, ".tvalid"}, 64'(tx_tvalid), 64'd0);
    check({tag, ".tkeep"},  64'(tx_tkeep),  64'd0);
    check({tag, ".tlast"},  64'(tx_tlast),  64'd0);
    check({tag, ".rdrdy"},  64'(rd_tready), 64'd0);
    check({tag, ".busy"},   64'(rsp_busy),  64'd0);
    check({tag, ".done"},   64'(rsp_done),  64'd0);
  endtask

  // Runs one packet. Called and returns at posedge+1. rdy_mode 0: tx_tready
  // always 1, 1: toggles 1/0. vld_mode 0: rd_tvalid always 1, 1: gapped.
  // pulse_cyc: cycle (0 = first header word) in which send_rsp is re-pulsed.
  task automatic run_pkt(input string tag, input logic [31:0] rsn, input logic [31:0] rc,
                         input int rdc, input logic [31:0] base,
                         input int rdy_mode, input int vld_mode, input int pulse_cyc);
    int cyc = 0, nwords = 0, bad_words = 0, nlast = 0, last_pos = -1;
    int keep_bad = 0, stall_bad = 0, stray_last = 0, rd_rdy_cyc = 0;
    int done_cyc = -1, rd_idx = 0, busy_bad = 0;
    int total = 3 + rdc;
    int limit = 4 * total + 20;
    bit done_seen = 0, stalled = 0;
    logic [31:0] held = '0, expw;

    rsp_ser_num    = rsn;
    rsp_code       = rc;
    rsp_data_count = CNT_W'(rdc);
    send_rsp       = 1'b1;
    rd_tvalid      = 1'b0;
    tx_tready      = 1'b0;
    @(posedge clk); #1;
    // Scramble the request inputs: the packet must use the latched values.
    rsp_ser_num    = ~rsn;
    rsp_code       = ~rc;
    rsp_data_count = ~CNT_W'(rdc);

    while (!done_seen && cyc < limit) begin
      tx_tready = (rdy_mode == 0) ? 1'b1 : ((cyc % 2) == 0);
      rd_tvalid = (vld_mode == 0) ? 1'b1 : (((cyc % 3) != 1) || stalled);
      rd_tdata  = rd_word(base, rd_idx);
      send_rsp  = (cyc == pulse_cyc);
      @(negedge clk);
      if (cyc == 0) check({tag, ".first_valid"}, 64'(tx_tvalid), 64'd1);
      if (stalled && (!tx_tvalid || tx_tdata !== held)) stall_bad++;
      if (tx_tvalid && tx_tkeep !== 4'hF) keep_bad++;
      if (!tx_tvalid && tx_tkeep !== 4'h0) keep_bad++;
      if (tx_tlast && !tx_tvalid) stray_last++;
      if (!rsp_busy) busy_bad++;
      if (tx_tvalid && tx_tready) begin
        if (nwords == 0)      expw = rsn;
        else if (nwords == 1) expw = rc;
        else if (nwords == 2) expw = 32'(rdc);
        else                  expw = rd_word(base, nwords - 3);
        if (tx_tdata !== expw) bad_words++;
        if (tx_tlast) begin
          nlast++;
          last_pos = nwords;
        end
        nwords++;
      end
      if (rd_tready) rd_rdy_cyc++;
      if (rd_tvalid && rd_tready) rd_idx++;
      if (rsp_done) begin
        done_seen = 1;
        done_cyc  = cyc;
      end
      stalled = tx_tvalid && !tx_tready;
      held    = tx_tdata;
      @(posedge clk); #1;
      cyc++;
    end
    send_rsp  = 1'b0;
    rd_tvalid = 1'b0;

    check({tag, ".done_seen"},  64'(done_seen),  64'd1);
    check({tag, ".nwords"},     64'(nwords),     64'(total));
    check({tag, ".bad_words"},  64'(bad_words),  64'd0);
    check({tag, ".nlast"},      64'(nlast),      64'd1);
    check({tag, ".last_pos"},   64'(last_pos),   64'(total - 1));
    check({tag, ".keep_bad"},   64'(keep_bad),   64'd0);
    check({tag, ".stall_bad"},  64'(stall_bad),  64'd0);
    check({tag, ".stray_last"}, 64'(stray_last), 64'd0);
    check({tag, ".busy_bad"},   64'(busy_bad),   64'd0);
    check({tag, ".rd_taken"},   64'(rd_idx),     64'(rdc));
    if (rdy_mode == 0 && vld_mode == 0) begin
      check({tag, ".done_cyc"}, 64'(done_cyc),   64'(total));
      check({tag, ".rd_rdy"},   64'(rd_rdy_cyc), 64'(rdc));
    end
    // Back in IDLE, and any send_rsp seen in DONE did not start a packet.
    @(negedge clk);
    check_quiet({tag, ".after"});
    @(posedge clk); #1;
    @(negedge clk);
    check_quiet({tag, ".after2"});
    @(posedge clk); #1;
  endtask

  initial begin
    reset          = 1'b1;
    send_rsp       = 1'b0;
    rsp_ser_num    = '0;
    rsp_code       = '0;
    rsp_data_count = '0;
    rd_tdata       = '0;
    rd_tvalid      = 1'b1;
    tx_tready      = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_quiet("reset_hold");
    @(posedge clk); #1;
    reset     = 1'b0;
    rd_tvalid = 1'b0;
    @(negedge clk);
    check_quiet("reset_idle");
    @(posedge clk); #1;

    // Header-only packet.
    run_pkt("rdc0", 32'h5, 32'h11, 0, 32'h0, 0, 0, -1);
    // Three data words, everything always ready.
    run_pkt("rdc3", 32'h100, 32'h200, 3, 32'hA, 0, 0, -1);
    // Backpressure and gapped source.
    run_pkt("bp2", 32'h1234, 32'h5678, 2, 32'h40, 1, 1, -1);
    run_pkt("bp5", 32'hCAFE, 32'hBEEF, 5, 32'h80, 1, 1, -1);
    // send_rsp re-pulsed during SEND_RC, then a fresh packet.
    run_pkt("pulse_rc", 32'h21, 32'h22, 1, 32'h90, 0, 0, 1);
    run_pkt("fresh", 32'h31, 32'h32, 2, 32'hA0, 0, 0, -1);
    // send_rsp present in the DONE cycle (cycle 3 + RDC).
    run_pkt("pulse_done", 32'h41, 32'h42, 2, 32'hB0, 0, 0, 5);

    // Reset in SEND_RD after one data word of a four-word packet.
    rsp_ser_num    = 32'h77;
    rsp_code       = 32'h78;
    rsp_data_count = 16'd4;
    send_rsp       = 1'b1;
    @(posedge clk); #1;
    send_rsp  = 1'b0;
    tx_tready = 1'b1;
    rd_tvalid = 1'b1;
    rd_tdata  = 32'hE0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("mid_rst.in_rd_rdrdy", 64'(rd_tready), 64'd1);
    check("mid_rst.in_rd_data",  64'(tx_tdata),  64'hE0);
    @(posedge clk); #1;
    rd_tdata = 32'hE1;
    reset    = 1'b1;
    @(negedge clk);
    check_quiet("mid_rst.during");
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_quiet("mid_rst.idle");
    @(posedge clk); #1;
    rd_tvalid = 1'b0;
    run_pkt("post_rst", 32'h51, 32'h52, 4, 32'hC0, 0, 0, -1);

    // Largest count: no counter wrap.
    run_pkt("rdc_max", 32'h61, 32'h62, (1 << CNT_W) - 1, 32'h1000, 0, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
